// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
//   AHB-Lite word-addressed SRAM slave. It has a read-only window, a fixed number of
//   wait states per transfer, and the standard two-cycle ERROR response.
//
// Ports
//   HCLK    : clock; all state changes on the rising edge
//   HRESET  : synchronous active-high reset; has priority over every other input
//   HADDR   : address-phase word address
//   HWRITE  : 1 = write, 0 = read
//   HSIZE   : transfer size; anything above word (3'b010) is rejected with ERROR
//   HBURST  : burst type; not used for addressing
//   HTRANS  : IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
//   HWDATA  : write data, valid in the data phase
//   HRDATA  : registered read data
//   HREADY  : transfer complete / ready for the next address
//   HRESP   : 0 = OKAY, 1 = ERROR
module ahb_lite_sram_slave #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_DEPTH     = 256,
  parameter int unsigned WAIT_STATES   = 0,
  parameter int unsigned RO_BASE       = 192,
  parameter int unsigned RO_LIMIT      = 255
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [ADDRESS_WIDTH-1:0] HADDR,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [2:0]               HBURST,
  input  logic [1:0]               HTRANS,
  input  logic [DATA_WIDTH-1:0]    HWDATA,
  output logic [DATA_WIDTH-1:0]    HRDATA,
  output logic                     HREADY,
  output logic                     HRESP
);

  localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         addr_q, addr_d;
  logic                    write_q, write_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                    hready;
  logic                    hresp;
  logic                    accept;
  logic                    addr_oob;
  logic                    ro_hit;
  logic                    bad_xfer;
  logic                    commit;
  logic                    mem_we;
  logic                    fwd_hit;
  logic [IdxW-1:0]         haddr_idx;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Burst type does not affect addressing; the master supplies every beat's address.
  logic unused_hburst;
  assign unused_hburst = ^HBURST;

  assign haddr_idx = HADDR[IdxW-1:0];

  always_comb begin
    hready     = 1'b1;
    hresp      = 1'b0;
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wait_cnt_d = wait_cnt_q;
    hrdata_d   = hrdata_q;

    unique case (state_q)
      StIdle, StData: begin
        hready = 1'b1;
        hresp  = 1'b0;
      end
      StWait: begin
        hready = 1'b0;
        hresp  = 1'b0;
      end
      StErr1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      StErr2: begin
        hready = 1'b1;
        hresp  = 1'b1;
      end
    endcase

    // A new address is only sampled while HREADY is high; BUSY/IDLE never start a transfer.
    accept   = hready & HTRANS[1];
    addr_oob = HADDR >= ADDRESS_WIDTH'(MEM_DEPTH);
    ro_hit   = (HADDR >= ADDRESS_WIDTH'(RO_BASE)) && (HADDR <= ADDRESS_WIDTH'(RO_LIMIT));
    bad_xfer = addr_oob | (HSIZE > 3'b010) | (HWRITE & ro_hit);

    // The write in the DATA cycle lands on the same edge a pipelined read may be accepted.
    commit  = (state_q == StData) & write_q;
    mem_we  = commit & ~HRESET;
    fwd_hit = commit && (addr_q == haddr_idx);
    rd_word = fwd_hit ? HWDATA : mem_q[haddr_idx];

    unique case (state_q)
      StWait: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = StData;
          if (!write_q) begin
            hrdata_d = mem_q[addr_q];
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StErr1: begin
        state_d = StErr2;
      end
      StIdle, StData, StErr2: begin
        state_d = StIdle;
        if (accept) begin
          if (bad_xfer) begin
            state_d = StErr1;
          end else begin
            addr_d  = haddr_idx;
            write_d = HWRITE;
            if (WAIT_STATES > 0) begin
              state_d    = StWait;
              wait_cnt_d = WaitInit;
            end else begin
              state_d = StData;
              if (!HWRITE) begin
                hrdata_d = rd_word;
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wait_cnt_q <= 4'd0;
      hrdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wait_cnt_q <= wait_cnt_d;
      hrdata_q   <= hrdata_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      mem_q[addr_q] <= HWDATA;
    end
  end

  assign HRDATA = hrdata_q;
  assign HREADY = hready;
  assign HRESP  = hresp;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: u0 runs with zero wait states, u2 with two. Both share the bus inputs;
// each phase resets first and only checks the instance whose timing it drives.
module tb_ahb_lite_sram_slave;

  localparam logic [1:0] TrIdle = 2'b00;
  localparam logic [1:0] TrBusy = 2'b01;
  localparam logic [1:0] TrNseq = 2'b10;
  localparam logic [1:0] TrSeq  = 2'b11;

  logic        clk;
  logic        rst;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata;

  logic [31:0] hrdata0, hrdata2;
  logic        hready0, hready2;
  logic        hresp0, hresp2;

  int checks = 0;
  int errors = 0;
  logic ro_intact;

  ahb_lite_sram_slave #(.WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
    .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0)
  );

  ahb_lite_sram_slave #(.WAIT_STATES(2)) u2 (
    .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
    .HRDATA(hrdata2), .HREADY(hready2), .HRESP(hresp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step past the next rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic w,
                       input logic [31:0] d);
    htrans = tr;
    haddr  = a;
    hwrite = w;
    hwdata = d;
  endtask

  initial begin
    rst = 1'b1; haddr = '0; hwrite = 1'b0; hsize = 3'b010; hburst = 3'b000;
    htrans = TrIdle; hwdata = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("rst_hready0", 32'(hready0), 32'd1);
    chk("rst_hresp0",  32'(hresp0),  32'd0);
    chk("rst_hrdata0", hrdata0, 32'h0);
    chk("rst_hready2", 32'(hready2), 32'd1);
    chk("rst_hresp2",  32'(hresp2),  32'd0);
    chk("rst_hrdata2", hrdata2, 32'h0);

    // ---- zero wait states: single write then read of addr 5
    drive(TrNseq, 32'd5, 1'b1, 32'h0);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'hDEADBEEF);
    chk("wr5_hready", 32'(hready0), 32'd1);
    tick();
    drive(TrNseq, 32'd5, 1'b0, 32'h0);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h0);
    chk("rd5_hrdata", hrdata0, 32'hDEADBEEF);
    chk("rd5_hresp",  32'(hresp0),  32'd0);
    chk("rd5_hready", 32'(hready0), 32'd1);
    tick();

    // ---- pipelined write/read of addr 9 exercises forwarding
    drive(TrNseq, 32'd9, 1'b1, 32'h0);
    tick();
    drive(TrNseq, 32'd9, 1'b0, 32'h1234);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h0);
    chk("fwd9_hrdata", hrdata0, 32'h1234);
    tick();

    // ---- INCR4 write at 16 with one BUSY after beat 2
    hburst = 3'b011;
    drive(TrNseq, 32'd16, 1'b1, 32'h0);
    tick();
    drive(TrSeq, 32'd17, 1'b1, 32'h11);
    tick();
    drive(TrBusy, 32'd18, 1'b1, 32'h22);
    tick();
    drive(TrSeq, 32'd18, 1'b1, 32'hBAD0BAD0);
    chk("busy_hready", 32'(hready0), 32'd1);
    chk("busy_hresp",  32'(hresp0),  32'd0);
    tick();
    drive(TrSeq, 32'd19, 1'b1, 32'h33);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h44);
    tick();
    // ---- INCR4 read back
    drive(TrNseq, 32'd16, 1'b0, 32'h0);
    tick();
    drive(TrSeq, 32'd17, 1'b0, 32'h0);
    chk("burst_rd16", hrdata0, 32'h11);
    tick();
    drive(TrSeq, 32'd18, 1'b0, 32'h0);
    chk("burst_rd17", hrdata0, 32'h22);
    tick();
    drive(TrSeq, 32'd19, 1'b0, 32'h0);
    chk("burst_rd18", hrdata0, 32'h33);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h0);
    chk("burst_rd19", hrdata0, 32'h44);
    chk("burst_hready", 32'(hready0), 32'd1);
    hburst = 3'b000;
    tick();

    // ---- sub-word write still stores the full word
    hsize = 3'b000;
    drive(TrNseq, 32'd10, 1'b1, 32'h0);
    tick();
    hsize = 3'b010;
    drive(TrNseq, 32'd10, 1'b0, 32'hCAFEF00D);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h0);
    chk("byte_wr10", hrdata0, 32'hCAFEF00D);
    chk("byte_hresp", 32'(hresp0), 32'd0);
    tick();

    // ---- write into read-only window: two-cycle ERROR, data not stored
    drive(TrNseq, 32'd200, 1'b1, 32'h0);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'hA5A5A5A5);
    chk("ro_err1_hready", 32'(hready0), 32'd0);
    chk("ro_err1_hresp",  32'(hresp0),  32'd1);
    tick();
    chk("ro_err2_hready", 32'(hready0), 32'd1);
    chk("ro_err2_hresp",  32'(hresp0),  32'd1);
    tick();
    chk("ro_post_hresp", 32'(hresp0), 32'd0);
    drive(TrNseq, 32'd200, 1'b0, 32'h0);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h0);
    ro_intact = (hrdata0 !== 32'hA5A5A5A5);
    chk("ro_rd200_intact", 32'(ro_intact), 32'd1);
    chk("ro_rd200_hresp",  32'(hresp0),    32'd0);
    tick();

    // ---- out-of-range read errors; pipelined read accepted in ERR2
    drive(TrNseq, 32'd256, 1'b0, 32'h0);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h0);
    chk("oob_err1_hready", 32'(hready0), 32'd0);
    chk("oob_err1_hresp",  32'(hresp0),  32'd1);
    tick();
    drive(TrNseq, 32'd5, 1'b0, 32'h0);
    chk("oob_err2_hready", 32'(hready0), 32'd1);
    chk("oob_err2_hresp",  32'(hresp0),  32'd1);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h0);
    chk("err2_pipe_hrdata", hrdata0, 32'hDEADBEEF);
    chk("err2_pipe_hresp",  32'(hresp0), 32'd0);
    tick();

    // ---- oversize HSIZE is an error
    hsize = 3'b011;
    drive(TrNseq, 32'd5, 1'b0, 32'h0);
    tick();
    hsize = 3'b010;
    drive(TrIdle, 32'd0, 1'b0, 32'h0);
    chk("size_err1_hresp", 32'(hresp0), 32'd1);
    chk("size_err1_hready", 32'(hready0), 32'd0);
    tick();
    tick();

    // ================= two wait states (u2) =================
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_hready", 32'(hready2), 32'd1);

    // write 0x77777777 to addr 7
    drive(TrNseq, 32'd7, 1'b1, 32'h0);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h77777777);
    chk("w7_wait1_hready", 32'(hready2), 32'd0);
    tick();
    chk("w7_wait2_hready", 32'(hready2), 32'd0);
    tick();
    chk("w7_data_hready", 32'(hready2), 32'd1);
    tick();

    // read addr 7; junk transfer on the bus during WAIT must be ignored
    drive(TrNseq, 32'd7, 1'b0, 32'h0);
    tick();
    drive(TrNseq, 32'd300, 1'b1, 32'h0);
    chk("r7_wait1_hready", 32'(hready2), 32'd0);
    chk("r7_wait1_hresp",  32'(hresp2),  32'd0);
    tick();
    chk("r7_wait2_hready", 32'(hready2), 32'd0);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h0);
    chk("r7_data_hready", 32'(hready2), 32'd1);
    chk("r7_data_hrdata", hrdata2, 32'h77777777);
    chk("r7_data_hresp",  32'(hresp2),  32'd0);
    tick();
    chk("r7_after_hresp", 32'(hresp2), 32'd0);

    // seed addr 3
    drive(TrNseq, 32'd3, 1'b1, 32'h0);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h33333333);
    tick(); tick(); tick();

    // write addr 3 interrupted by reset during WAIT
    drive(TrNseq, 32'd3, 1'b1, 32'h0BADBAD0);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h0BADBAD0);
    chk("rstw_wait_hready", 32'(hready2), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_hready", 32'(hready2), 32'd1);
    chk("rstw_hresp",  32'(hresp2),  32'd0);
    chk("rstw_hrdata", hrdata2, 32'h0);
    tick(); tick();

    // addr 3 keeps its seeded value
    drive(TrNseq, 32'd3, 1'b0, 32'h0);
    tick();
    drive(TrIdle, 32'd0, 1'b0, 32'h0);
    tick(); tick();
    chk("rd3_hready", 32'(hready2), 32'd1);
    chk("rd3_hrdata", hrdata2, 32'h33333333);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
